// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO and its storage.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_AE_LEVEL   = 2;

  // Pointer width: enough bits to address DEPTH entries.
  function automatic int ADDR_W(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so the value DEPTH itself is representable.
  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// Storage for the synchronous FIFO: one synchronous write port and one
// registered read port. The array itself is never reset so it maps to block RAM;
// only the read data register is cleared.
module fifo_mem_1r1w
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_W(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  input  logic [ADDR_W(DEPTH)-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: register the addressed word on an accepted read, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy count, full/empty and threshold flags.
// Optional sticky overflow/underflow flags are built only when the macro
// SYNC_FIFO_ERR_FLAGS_EN is defined; otherwise those ports are tied low.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic                     read_en,
  input  logic [DATA_WIDTH-1:0]    in,
  output logic [DATA_WIDTH-1:0]    out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [CNT_W(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = ADDR_W(DEPTH);
  localparam int CW = CNT_W(DEPTH);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          wr_accept;
  logic          rd_accept;

  // A request is honoured only when the FIFO can service it; when full and
  // both are requested the read wins, when empty the write wins.
  assign wr_accept = write_en & ~full;
  assign rd_accept = read_en & ~empty;

  assign full         = (count_reg == FULL_CNT);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign count        = count_reg;

  fifo_mem_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (in),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_reg),
    .rd_data (out)
  );

  // Occupancy changes only when exactly one side is accepted.
  always_comb begin
    count_next = count_reg;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  // Sticky error flags: set on any request the FIFO cannot honour, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (write_en && full)  overflow_reg  <= 1'b1;
      if (read_en  && empty) underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk;
  logic          reset;
  logic          write_en;
  logic          read_en;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  sync_fifo_flags #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_en     (write_en),
    .read_en      (read_en),
    .in           (din),
    .out          (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_out;
  bit            m_ovf;
  bit            m_udf;
  int            checks;
  int            errors;
  int            nstep;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare every output.
  task automatic step(input bit rst, input bit wr, input bit rd, input logic [DW-1:0] d);
    bit rd_ok;
    bit wr_ok;
    int n;
    reset    = rst;
    write_en = wr;
    read_en  = rd;
    din      = d;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_out = '0;
      m_ovf = 0;
      m_udf = 0;
    end else begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      if (wr && q.size() == DEPTH) m_ovf = 1;
      if (rd && q.size() == 0)     m_udf = 1;
`endif
      rd_ok = rd && (q.size() != 0);
      wr_ok = wr && (q.size() != DEPTH);
      if (rd_ok) m_out = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
    n = q.size();
    check("count",        32'(count),        32'(n));
    check("full",         32'(full),         32'(n == DEPTH));
    check("empty",        32'(empty),        32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("out",          32'(dout),         32'(m_out));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_udf));
    nstep++;
    $display("step %0d rst=%0b wr=%0b rd=%0b in=%02h count=%0d out=%02h ovf=%0b udf=%0b",
             nstep, rst, wr, rd, d, count, dout, overflow, underflow);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    checks   = 0;
    errors   = 0;
    nstep    = 0;
    m_out    = '0;
    reset    = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    din      = '0;

    // Reset for two cycles with a write pending: reset must win.
    step(1, 1, 0, 8'hAA);
    step(1, 1, 0, 8'hAB);
    check("reset_count", 32'(count), 32'd0);
    check("reset_out",   32'(dout),  32'd0);

    // Fill with 0x01..0x08 then drain in order.
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, 8'(i));
    check("fill_full", 32'(full), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 0, 1, 8'h00);
      check("drain_order", 32'(dout), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Thresholds: up to 6, then down to 2.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'($urandom));
    check("af_at_6", 32'(almost_full), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
    check("ae_at_2", 32'(almost_empty), 32'd1);

    // Simultaneous access at full: read wins, write dropped.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'($urandom));
    step(0, 1, 1, 8'h5A);
    check("both_at_full_count", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h00);
    // Simultaneous access at empty: write wins, out held.
    held = dout;
    step(0, 1, 1, 8'hC3);
    check("both_at_empty_count", 32'(count), 32'd1);
    check("both_at_empty_out",   32'(dout),  32'(held));
    step(0, 0, 1, 8'h00);
    check("both_at_empty_data",  32'(dout),  32'hC3);

    // Error conditions: read while empty, write while full, then stickiness.
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'($urandom));
    step(0, 1, 0, 8'hEE);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'h00);

    // Wrap-around: 5 in, 5 out, 8 in, 8 out.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'($urandom));
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, at least 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port write_en, input, 1, write request.
REQ-008 SHALL have port read_en, input, 1, read request.
REQ-009 SHALL have port in, input, DATA_WIDTH, write data.
REQ-010 SHALL have port out, output, DATA_WIDTH, registered read data.
REQ-011 SHALL have ports full and empty, output, 1 each, occupancy limit flags.
REQ-012 SHALL have ports almost_full and almost_empty, output, 1 each, threshold flags.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1, current occupancy from 0 to DEPTH.
REQ-014 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-015 SHALL accept a write exactly when write_en=1 and full=0; an accepted write stores in at wr_ptr and increments wr_ptr modulo DEPTH.
REQ-016 SHALL accept a read exactly when read_en=1 and empty=0; an accepted read loads out with mem[rd_ptr] on the same edge and increments rd_ptr modulo DEPTH.
REQ-017 SHALL present read data on out one cycle after the read request (1-cycle latency); out SHALL hold its value when no read is accepted.
REQ-018 SHALL update count as follows: +1 on a write-only accept, -1 on a read-only accept, unchanged on a simultaneous accept or no accept.
REQ-019 SHALL derive the flags from count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-020 SHALL, when full and both requests are high, accept the read and reject the write; count drops to DEPTH-1.
REQ-021 SHALL, when empty and both requests are high, accept the write and reject the read; out is unchanged and count becomes 1.
REQ-022 SHALL wrap both pointers from DEPTH-1 to 0 with no loss of data or ordering.
REQ-023 SHALL leave memory contents and pointers unchanged on rejected requests.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, set wr_ptr=0, rd_ptr=0, count=0, out=0, overflow=0 and underflow=0; flags then read empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-025 SHALL give reset priority over concurrent write_en and read_en; a reset asserted mid-operation discards all stored entries.
REQ-026 SHALL leave memory array contents uninitialised by reset.

Configuration
REQ-027 SHALL compile in overflow and underflow logic only when the macro SYNC_FIFO_ERR_FLAGS_EN is defined.
REQ-028 SHALL, with the macro defined, set overflow on any edge where write_en=1 and full=1, and set underflow on any edge where read_en=1 and empty=1; both flags are cleared only by reset.
REQ-029 SHALL, without the macro, keep both ports present and tie them to 0, with no associated registers.

Structure
REQ-030 SHALL place the ADDR_W/CNT_W width helper functions and the default parameter constants in the shared package sync_fifo_pkg.
REQ-031 SHALL implement storage in one sub-module, fifo_mem_1r1w: one synchronous write port and one registered read port, parametrised by DATA_WIDTH and DEPTH.

Verification
REQ-032 SHALL cover reset: assert reset for 2 cycles with write_en=1 -> count=0, empty=1, almost_empty=1, out=0.
REQ-033 SHALL cover fill and drain: write 0x01..0x08, then read 8 times -> full=1 after the 8th write; out=0x01..0x08 in order, each 1 cycle after its read; empty=1 at the end.
REQ-034 SHALL cover thresholds: write 6 words -> almost_full=1 at count=6; read down to 2 -> almost_empty=1 at count=2.
REQ-035 SHALL cover simultaneous access: at count=8, assert both requests -> count=7 and the write is dropped; at count=0, assert both -> count=1 and out is unchanged.
REQ-036 SHALL cover wrap-around: write 5, read 5, write 8, read 8 -> data order preserved across the pointer wrap.
REQ-037 SHALL cover the error flags, with SYNC_FIFO_ERR_FLAGS_EN defined: write when full -> overflow=1 and it stays high until reset; read when empty -> underflow=1.
